// File: rtl/ysyx_24110026_core_seq_pkg.sv
// ysyx_24110026_core_seq_pkg: shared state encoding and defaults for the core sequencer.
//   state_t        sequencer states, FETCH through HALT
//   RESET_PC_DEF   PC value loaded on reset
//   TIMEOUT_W_DEF  fetch-wait timer width
//   misaligned()   true when a jump target is not word aligned
package ysyx_24110026_core_seq_pkg;
    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_EXEC, S_MREQ, S_MWAIT, S_WB, S_HALT
    } state_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int TIMEOUT_W_DEF = 8;
    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/ysyx_24110026_core_seq_fetch_timer.sv
// ysyx_24110026_fetch_timer: counts instruction-fetch wait cycles and flags a timeout.
//   clk_i      core clock
//   rst_ni     asynchronous active-low reset
//   clear_i    restart the count from zero
//   inc_i      advance the count by one
//   expired_o  high during the (2**W-1)-th wait cycle since the last clear
module ysyx_24110026_fetch_timer #(
    parameter int W = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam logic [W-1:0] ONE = W'(1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (inc_i) cnt_q <= cnt_q + ONE;
    end
    // The count reads k in the (k+1)-th wait cycle, so all-ones-minus-one marks the last allowed one.
    assign expired_o = cnt_q == ~ONE;
endmodule

// File: rtl/ysyx_24110026_core_seq.sv
// ysyx_24110026_core_seq: multi-cycle FETCH/WAIT/EXEC/MREQ/MWAIT/WB sequencer for the RV32E core.
//   clk, rst                      clock; asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*         instruction fetch request (valid/ready/addr) and response (valid/inst/err)
//   inst                          latched instruction for the decoder
//   dec_mem, dec_wb, dec_ebreak   decoder flags for the latched instruction
//   br_taken, br_target           branch outcome, sampled in EXEC
//   lsu_req_valid/ready, lsu_rsp_valid   data access handshake
//   rf_wen, pc, pc_en             regfile write strobe, architectural PC and its update pulse
//   halt, trap, retired           halted flag, halt cause (1 fault, 0 ebreak), retired count
module ysyx_24110026_core_seq
    import ysyx_24110026_core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    input  logic        ifu_rsp_err,
    output logic [31:0] inst,
    input  logic        dec_mem,
    input  logic        dec_wb,
    input  logic        dec_ebreak,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        pc_en,
    output logic        halt,
    output logic        trap,
    output logic [31:0] retired
);
    state_t      state_q;
    logic [31:0] pc_q, npc_q, inst_q, retired_q;
    logic        trap_q, tmr_expired;

    ysyx_24110026_fetch_timer #(.W(TIMEOUT_W)) u_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clear_i  (state_q == S_FETCH),
        .inc_i    (state_q == S_WAIT),
        .expired_o(tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            npc_q     <= '0;
            inst_q    <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (ifu_req_ready) state_q <= S_WAIT;
                S_WAIT: begin
                    // A response wins over a timeout that expires in the same cycle.
                    if (ifu_rsp_valid && !ifu_rsp_err) begin
                        inst_q  <= ifu_rsp_inst;
                        state_q <= S_EXEC;
                    end else if (ifu_rsp_valid || tmr_expired) begin
                        trap_q  <= 1'b1;
                        state_q <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (dec_ebreak) begin
                        trap_q  <= 1'b0;
                        state_q <= S_HALT;
                    end else if (br_taken && misaligned(br_target)) begin
                        trap_q  <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        npc_q   <= br_taken ? br_target : pc_q + 32'd4;
                        state_q <= dec_mem ? S_MREQ : S_WB;
                    end
                end
                S_MREQ:  if (lsu_req_ready) state_q <= lsu_rsp_valid ? S_WB : S_MWAIT;
                S_MWAIT: if (lsu_rsp_valid) state_q <= S_WB;
                S_WB: begin
                    pc_q      <= npc_q;
                    retired_q <= retired_q + 32'd1;
                    state_q   <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Request valids are gated by reset so they drop the moment reset asserts.
    assign ifu_req_valid = rst && state_q == S_FETCH;
    assign lsu_req_valid = rst && state_q == S_MREQ;
    assign ifu_req_addr  = pc_q;
    assign inst          = inst_q;
    assign rf_wen        = state_q == S_WB && dec_wb;
    assign pc            = pc_q;
    assign pc_en         = state_q == S_WB;
    assign halt          = state_q == S_HALT;
    assign trap          = trap_q;
    assign retired       = retired_q;
endmodule

// File: tb/tb_ysyx_24110026_core_seq.sv
// tb_ysyx_24110026_core_seq: scripted-timeline model of the core sequencer under random stimulus.
module tb_ysyx_24110026_core_seq;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_req_addr, ifu_rsp_inst, inst, br_target, pc, retired;
    logic        dec_mem, dec_wb, dec_ebreak, br_taken;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        rf_wen, pc_en, halt, trap;

    ysyx_24110026_core_seq #(.RESET_PC(RST_PC), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
        .inst(inst), .dec_mem(dec_mem), .dec_wb(dec_wb), .dec_ebreak(dec_ebreak),
        .br_taken(br_taken), .br_target(br_target),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .rf_wen(rf_wen), .pc(pc), .pc_en(pc_en), .halt(halt), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, halt_cyc = 0, t0 = 0;
    logic [31:0] m_pc, m_retired, m_inst;
    logic        m_halt, m_trap;
    logic        e_ifu, e_lsu, e_rf, e_pcen;
    logic        chk_en = 1'b0, halt_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (halt === 1'b1 && !halt_seen) begin
            halt_seen = 1'b1;
            halt_cyc  = cyc;
        end
        if (chk_en) begin
            chk("ifu_req_valid", 32'(ifu_req_valid), 32'(e_ifu));
            if (e_ifu) chk("ifu_req_addr", ifu_req_addr, m_pc);
            chk("lsu_req_valid", 32'(lsu_req_valid), 32'(e_lsu));
            chk("rf_wen", 32'(rf_wen), 32'(e_rf));
            chk("pc_en", 32'(pc_en), 32'(e_pcen));
            chk("halt", 32'(halt), 32'(m_halt));
            chk("trap", 32'(trap), 32'(m_trap));
            chk("pc", pc, m_pc);
            chk("retired", retired, m_retired);
            chk("inst", inst, m_inst);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setexp(input logic i, input logic l, input logic r, input logic p);
        e_ifu = i; e_lsu = l; e_rf = r; e_pcen = p;
    endtask

    task automatic quiet();
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_inst = $urandom;
        dec_mem = 0; dec_wb = 0; dec_ebreak = 0; br_taken = 0; br_target = $urandom;
        lsu_req_ready = 0; lsu_rsp_valid = 0;
    endtask

    task automatic noise();
        ifu_req_ready = 1'($urandom); ifu_rsp_valid = 1'($urandom); ifu_rsp_err = 1'($urandom);
        ifu_rsp_inst = $urandom; dec_mem = 1'($urandom); dec_wb = 1'($urandom);
        dec_ebreak = 1'($urandom); br_taken = 1'($urandom); br_target = $urandom;
        lsu_req_ready = 1'($urandom); lsu_rsp_valid = 1'($urandom);
    endtask

    task automatic halted(input logic t);
        m_halt = 1'b1;
        m_trap = t;
        for (int k = 0; k < 6; k++) begin
            noise();
            setexp(0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_retired", retired, 0);
        chk("rst_inst", inst, 0);
        chk("rst_ifu_valid", 32'(ifu_req_valid), 0);
        chk("rst_lsu_valid", 32'(lsu_req_valid), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_rf_wen", 32'(rf_wen), 0);
        quiet();
        tick();
        tick();
        m_pc = RST_PC; m_retired = 0; m_inst = 0; m_halt = 0; m_trap = 0;
        halt_seen = 1'b0;
        rst = 1'b1;
        chk_en = 1'b1;
    endtask

    // One instruction: a not-ready fetch cycles, response after b wait cycles (or timeout),
    // then EXEC, optional data access (ready after c cycles, response d cycles later), then WB.
    task automatic run(input int a, input int b, input bit err, input bit tmo, input bit ebk,
                       input bit mem, input int c, input int d, input bit br,
                       input logic [31:0] tgt, input bit wb, input bit abort);
        logic [31:0] ins, npc;
        ins = $urandom;
        for (int i = 0; i <= a; i++) begin
            quiet();
            dec_mem = 1'($urandom); dec_wb = 1'($urandom); dec_ebreak = 1'($urandom);
            lsu_rsp_valid = 1'($urandom); ifu_rsp_valid = 1'($urandom);
            ifu_req_ready = i == a;
            setexp(1, 0, 0, 0);
            tick();
        end
        acc_cyc = cyc;
        for (int j = 0; j < (tmo ? 15 : b + 1); j++) begin
            quiet();
            dec_wb = 1'($urandom); lsu_rsp_valid = 1'($urandom);
            ifu_rsp_valid = !tmo && j == b;
            ifu_rsp_err = ifu_rsp_valid ? err : 1'($urandom);
            if (ifu_rsp_valid) ifu_rsp_inst = ins;
            setexp(0, 0, 0, 0);
            tick();
        end
        if (tmo || err) begin
            halted(1);
            return;
        end
        m_inst = ins;
        quiet();
        dec_mem = mem; dec_wb = wb; dec_ebreak = ebk; br_taken = br; br_target = tgt;
        lsu_rsp_valid = 1'($urandom);
        setexp(0, 0, 0, 0);
        tick();
        if (ebk) begin
            halted(0);
            return;
        end
        if (br && tgt[1:0] != 2'b00) begin
            halted(1);
            return;
        end
        npc = br ? tgt : m_pc + 32'd4;
        if (mem) begin
            for (int i = 0; i <= c; i++) begin
                lsu_req_ready = i == c;
                lsu_rsp_valid = i == c && d == 0;
                ifu_rsp_valid = 1'($urandom);
                setexp(0, 1, 0, 0);
                tick();
            end
            for (int j = 1; j <= d; j++) begin
                lsu_req_ready = 1'($urandom);
                lsu_rsp_valid = j == d && !abort;
                setexp(0, 0, 0, 0);
                if (abort) begin
                    #2;
                    return;
                end
                tick();
            end
        end
        lsu_req_ready = 0;
        lsu_rsp_valid = 1'($urandom);
        ifu_rsp_valid = 1'($urandom);
        setexp(0, 0, wb, 1);
        tick();
        m_pc = npc;
        m_retired = m_retired + 1;
    endtask

    initial begin
        quiet();
        setexp(0, 0, 0, 0);
        #2;
        do_reset();
        t0 = cyc;
        repeat (3) run(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("addi_pc", pc, 32'h8000_000C);
        chk("addi_retired", retired, 3);
        chk("addi_cycles", 32'(cyc - t0), 12);
        chk("model_pc", m_pc, 32'h8000_000C);
        run(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("stall_pc", pc, 32'h8000_0010);
        run(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0100, 1, 0);
        chk("branch_pc", pc, 32'h8000_0100);
        run(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 1, 0);
        chk("load_pc", pc, 32'h8000_0104);
        run(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        run(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("wrap_pc", pc, 32'h0);
        run(0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("late_rsp_halt", 32'(halt), 0);
        chk("late_rsp_pc", pc, 32'h4);
        run(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0102, 1, 0);
        chk("misalign_halt", 32'(halt), 1);
        chk("misalign_trap", 32'(trap), 1);
        chk("misalign_pc", pc, 32'h4);
        do_reset();
        run(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("ebreak_halt", 32'(halt), 1);
        chk("ebreak_trap", 32'(trap), 0);
        chk("ebreak_retired", retired, 1);
        do_reset();
        run(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("timeout_latency", 32'(halt_cyc - acc_cyc), 15);
        chk("timeout_trap", 32'(trap), 1);
        do_reset();
        run(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 1);
        do_reset();
        repeat (400) begin
            int r, a, b, c, d;
            bit tmo, err, ebk, mis, br, mem;
            logic [31:0] tgt;
            r   = $urandom_range(0, 99);
            tmo = r < 3;
            err = r >= 3 && r < 6;
            ebk = r >= 6 && r < 9;
            mis = r >= 9 && r < 12;
            a   = $urandom_range(0, 3);
            b   = (r >= 12 && r < 15) ? $urandom_range(12, 14) : $urandom_range(0, 4);
            c   = $urandom_range(0, 3);
            d   = $urandom_range(0, 3);
            mem = $urandom_range(0, 2) == 0;
            br  = mis || $urandom_range(0, 3) == 0;
            tgt = $urandom;
            tgt[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
            run(a, b, err, tmo, ebk, mem, c, d, br, tgt, 1'($urandom), 0);
            if (m_halt) do_reset();
        end
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
